ssc_tx_capture: RTL
===================

SSC_TX_CAPTURE -- requirements
Module: ssc_tx_capture

Interface
REQ-001 SHALL have parameter CLOCK_SPEED_HZ, default 54_000_000, the clk_logic frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, the serial bit rate (8N1 framing).
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, the number of byte entries; power of two, 2..256.
REQ-004 SHALL have port clk_logic, input, 1, the single clock; all logic rising-edge.
REQ-005 SHALL have port system_reset_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port serial_i, input, 1, serial stream from the SSC UART TX output, idle high, asynchronous to clk_logic.
REQ-007 SHALL have port data_o, output, 8, the byte at the FIFO head.
REQ-008 SHALL have port valid_o, output, 1, high when the FIFO is non-empty.
REQ-009 SHALL have port ready_i, input, 1, consumer accept; a pop occurs when valid_o and ready_i are both high.
REQ-010 SHALL have port count_o, output, $clog2(FIFO_DEPTH)+1, the current FIFO occupancy.
REQ-011 SHALL have port framing_err_o, output, 1, a one-cycle pulse on a bad stop bit.
REQ-012 SHALL have port overflow_o, output, 1, a one-cycle pulse when a received byte is dropped.

Function
REQ-013 SHALL pass serial_i through a 2-flop synchronizer; all decisions SHALL use the synchronized value (rx_s).
REQ-014 SHALL use BIT_TICKS = CLOCK_SPEED_HZ / BAUD_RATE, integer-truncated, and HALF_TICKS = BIT_TICKS / 2.
REQ-015 SHALL use a tick counter wide enough for BIT_TICKS-1; the counter SHALL clear on every state transition.
REQ-016 SHALL implement the states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-017 IDLE: when rx_s is 0 (start edge), SHALL go to START.
REQ-018 START: when the counter reaches HALF_TICKS-1, SHALL sample rx_s.
  - rx_s = 1: glitch; SHALL return to IDLE with no error.
  - rx_s = 0: SHALL go to DATA with bit index 0.
REQ-019 DATA: SHALL sample rx_s when the counter reaches BIT_TICKS-1.
  - Bits SHALL be shifted LSB first.
  - After bit index 7, SHALL go to STOP.
REQ-020 STOP: SHALL sample rx_s when the counter reaches BIT_TICKS-1.
  - rx_s = 1: SHALL request a push of the assembled byte and go to IDLE.
  - rx_s = 0: SHALL pulse framing_err_o for one cycle, discard the byte and go to WAIT_HIGH.
REQ-021 WAIT_HIGH: SHALL stay until rx_s is 1, then go to IDLE; a held line (break) SHALL produce exactly one framing_err_o pulse.
REQ-022 Push latency: valid_o/data_o SHALL reflect a byte pushed into an empty FIFO on the cycle after the stop-bit sample; there SHALL be no combinational fall-through.
REQ-023 Push when full with no simultaneous pop: SHALL drop the byte, pulse overflow_o for one cycle, and leave the FIFO contents and count_o unchanged.
REQ-024 Push and pop in the same cycle: when full, SHALL accept both with no overflow and count unchanged; when non-empty, count SHALL be unchanged.
REQ-025 Pop when empty SHALL have no effect; valid_o low SHALL make ready_i a don't-care.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH; count_o SHALL equal FIFO_DEPTH exactly when full.
REQ-027 data_o SHALL be stable while valid_o is high and ready_i is low.
REQ-028 framing_err_o and overflow_o SHALL never be asserted on the same cycle as each other.

Reset
REQ-029 On system_reset_n low: state IDLE, counters 0, both synchronizer flops 1, FIFO pointers 0.
REQ-030 Reset output values: count_o 0, valid_o 0, data_o 8'h00, framing_err_o 0, overflow_o 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no push and no error pulse; the first frame after release SHALL be received normally.

Verification (bench parameters CLOCK_SPEED_HZ=1_600_000, BAUD_RATE=100_000, so BIT_TICKS=16; FIFO_DEPTH=4)
REQ-032 Send 8'hA5 8N1 with ready_i=0 -> valid_o=1, data_o=8'hA5, count_o=1; no error pulses.
REQ-033 Send 8'h01..8'h05 with ready_i=0 -> bytes 01..04 held, count_o=4; one overflow_o pulse on byte 05; popping yields 01,02,03,04.
REQ-034 Send 8'h3C with stop bit 0, then hold the line low 40 bit times, then release high and send 8'h7E -> exactly one framing_err_o pulse; only 8'h7E enters the FIFO.
REQ-035 Apply a 5-cycle low glitch on an idle line -> returns to IDLE; no push, no error.
REQ-036 FIFO full (4) with ready_i=1 held, and a stop sample coinciding with a pop -> no overflow; count_o stays 4; order preserved.
REQ-037 Assert system_reset_n low during DATA bit 3 of 8'hFF, release, then send 8'h55 -> count_o=1, data_o=8'h55.

Source files
------------

// File: rtl/ssc_tx_capture.sv
// Captures the SSC UART TX line (8N1), assembles bytes and queues them in a
// small FIFO with a valid/ready consumer port, flagging framing errors and overflows.
module ssc_tx_capture #(
    parameter int CLOCK_SPEED_HZ = 54_000_000,
    parameter int BAUD_RATE      = 9600,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                        clk_logic,
    input  logic                        system_reset_n,
    input  logic                        serial_i,
    output logic [7:0]                  data_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [$clog2(FIFO_DEPTH):0] count_o,
    output logic                        framing_err_o,
    output logic                        overflow_o
);

    localparam int BIT_TICKS  = CLOCK_SPEED_HZ / BAUD_RATE;
    localparam int HALF_TICKS = BIT_TICKS / 2;
    localparam int TICK_W     = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(BIT_TICKS - 1);
    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(HALF_TICKS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_e;

    // ------------------------------------------------------------------
    // Input synchronizer (resets to the idle-high line level)
    // ------------------------------------------------------------------
    logic [1:0] sync_q, sync_d;
    logic       rx_s;

    always_comb begin
        sync_d = {sync_q[0], serial_i};
    end

    // NOTE: sequential state always uses <= so every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rx_s = sync_q[1];

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    rx_state_e         state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              framing_err_q, framing_err_d;
    logic              push_req;

    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        tick_d        = tick_q + TICK_W'(1);
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        framing_err_d = 1'b0;
        push_req      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                tick_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // Mid-start-bit recheck rejects short glitches on an idle line.
                if (tick_q == HALF_LAST) begin
                    tick_d = '0;
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_DATA;
                        bit_idx_d = 3'd0;
                    end
                end
            end
            ST_DATA: begin
                if (tick_q == BIT_LAST) begin
                    tick_d    = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (tick_q == BIT_LAST) begin
                    tick_d = '0;
                    if (rx_s) begin
                        push_req = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        framing_err_d = 1'b1;
                        state_d       = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                // A held-low line (break) reports once, then waits here silently.
                tick_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                tick_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state_q       <= ST_IDLE;
            tick_q        <= '0;
            bit_idx_q     <= 3'd0;
            shift_q       <= 8'h00;
            framing_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_q        <= tick_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            framing_err_q <= framing_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             pop;
    logic             full;
    logic             wr_en;

    assign valid_o = (count_q != '0);

    always_comb begin
        pop        = valid_o && ready_i;
        full       = (count_q == FULL_CNT);
        // A simultaneous pop frees the head slot, so a full FIFO still accepts the byte.
        wr_en      = push_req && (!full || pop);
        overflow_d = push_req && full && !pop;

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage has no reset; entries are only observable once written, and data_o is gated by valid_o.
    always_ff @(posedge clk_logic) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign data_o        = valid_o ? mem_q[rd_ptr_q] : 8'h00;
    assign count_o       = count_q;
    assign framing_err_o = framing_err_q;
    assign overflow_o    = overflow_q;

endmodule
